// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L1-to-L2 line arbiter: word/line types and the
// arbiter FSM and owner encodings.
package rv32i_types;

  typedef logic [31:0]  rv32i_word;
  typedef logic [255:0] l2_line_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
  typedef enum logic       {SRC_I, SRC_D}     arb_src_t;

  localparam rv32i_word LINE_ADDR_MASK = 32'hFFFF_FFE0;

  // L2 transfers whole 32-byte lines, so the byte offset is always zero.
  function automatic rv32i_word line_align(input rv32i_word addr);
    return addr & LINE_ADDR_MASK;
  endfunction

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of the I-side, D-side and L2 line-port signals seen by the arbiter.
// master = arbiter side, slave = the caches/L2 around it.
interface l2_arbiter_if;
  import rv32i_types::*;

  logic      icache_read;
  rv32i_word icache_address;
  l2_line_t  icache_rdata;
  logic      icache_resp;

  logic      dcache_read;
  logic      dcache_write;
  rv32i_word dcache_address;
  l2_line_t  dcache_wdata;
  l2_line_t  dcache_rdata;
  logic      dcache_resp;

  logic      l2_read;
  logic      l2_write;
  rv32i_word l2_address;
  l2_line_t  l2_wdata;
  l2_line_t  l2_rdata;
  logic      l2_resp;

  modport master (
    input  icache_read, icache_address,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output l2_read, l2_write, l2_address, l2_wdata,
    input  l2_rdata, l2_resp
  );

  modport slave (
    output icache_read, icache_address,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  l2_read, l2_write, l2_address, l2_wdata,
    output l2_rdata, l2_resp
  );

endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter of the I-side and D-side L1 caches onto one L2 line port.
// Every output comes straight from a flop or from registered state only.
module l2_arbiter
  import rv32i_types::*;
(
  input  logic          clk,
  input  logic          rst,
  l2_arbiter_if.master  bus
);

  arb_state_t state_q, state_d;
  arb_src_t   last_grant_q;
  arb_src_t   src_q;

  logic       l2_read_q;
  logic       l2_write_q;
  rv32i_word  l2_address_q;
  l2_line_t   l2_wdata_q;
  l2_line_t   rbuf_q;

  logic       grant_i;
  logic       grant_d;
  logic       take_resp;
  logic       i_req;
  logic       d_req;

  assign i_req = bus.icache_read;
  assign d_req = bus.dcache_read | bus.dcache_write;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    take_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          // Under contention the side that did not win last time goes next.
          grant_d = (last_grant_q == SRC_I);
          grant_i = (last_grant_q == SRC_D);
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
        if (grant_i || grant_d) state_d = BUSY;
      end
      BUSY: begin
        if (bus.l2_resp) begin
          take_resp = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and the update order inside the block is moot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= SRC_I;
      src_q        <= SRC_I;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_address_q <= '0;
      l2_wdata_q   <= '0;
      rbuf_q       <= '0;
    end else begin
      if (grant_i) begin
        src_q        <= SRC_I;
        last_grant_q <= SRC_I;
        l2_read_q    <= 1'b1;
        l2_write_q   <= 1'b0;
        l2_address_q <= line_align(bus.icache_address);
      end else if (grant_d) begin
        // A simultaneous read+write from the D side is resolved as a write.
        src_q        <= SRC_D;
        last_grant_q <= SRC_D;
        l2_read_q    <= ~bus.dcache_write;
        l2_write_q   <= bus.dcache_write;
        l2_address_q <= line_align(bus.dcache_address);
        l2_wdata_q   <= bus.dcache_wdata;
      end
      if (take_resp) begin
        rbuf_q     <= bus.l2_rdata;
        l2_read_q  <= 1'b0;
        l2_write_q <= 1'b0;
      end
    end
  end

  assign bus.l2_read      = l2_read_q;
  assign bus.l2_write     = l2_write_q;
  assign bus.l2_address   = l2_address_q;
  assign bus.l2_wdata     = l2_wdata_q;

  assign bus.icache_resp  = (state_q == DONE) && (src_q == SRC_I);
  assign bus.dcache_resp  = (state_q == DONE) && (src_q == SRC_D);
  assign bus.icache_rdata = rbuf_q;
  assign bus.dcache_rdata = rbuf_q;

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Arbitrates the instruction-side and data-side L1 caches onto the single 256-bit line port of the L2 cache. Acts as the initiator on the L2 request interface (read/write/address/wdata out, rdata/resp in) and as responder to each L1's line-miss request. All L2-facing outputs are registered, and the arbitration is round-robin under contention.

## Interface
- No parameters. Line width is fixed at 256 bits; addresses are `rv32i_word`.
- `clk` in 1 — system clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `icache_read` in 1 — I-side line read request; level, held until `icache_resp`.
- `icache_address` in 32 — I-side line address; bits [4:0] are ignored.
- `icache_rdata` out 256 — returned line; valid only while `icache_resp`=1.
- `icache_resp` out 1 — one-cycle completion pulse.
- `dcache_read` in 1 — D-side line read request; level, held until `dcache_resp`.
- `dcache_write` in 1 — D-side line write-back request; level, held until `dcache_resp`.
- `dcache_address` in 32 — D-side line address.
- `dcache_wdata` in 256 — write-back line.
- `dcache_rdata` out 256 — returned line; valid only while `dcache_resp`=1.
- `dcache_resp` out 1 — one-cycle completion pulse.
- `l2_read` out 1 — request to L2, registered.
- `l2_write` out 1 — request to L2, registered.
- `l2_address` out 32 — registered; bits [4:0] are forced to 0.
- `l2_wdata` out 256 — registered.
- `l2_rdata` in 256 — L2 line data; sampled on `l2_resp`.
- `l2_resp` in 1 — L2 completion; asserts for one or more cycles.

## Operation
- The FSM has three states: IDLE, BUSY, DONE. There is a `last_grant` bit (I or D) and a `src` bit for the current owner.
- **IDLE, no pending request:** stay in IDLE.
- **IDLE, only one side requests:** grant that side.
- **IDLE, both sides request:** grant the side that is not `last_grant`.
  - `last_grant` resets to I, so the first contention goes to D.
- **On grant:**
  - Register the address with [4:0]=0, register `dcache_wdata` (D side only), and set `src`.
  - Set `l2_read` or `l2_write`.
  - Set `last_grant` = granted side.
  - Go to BUSY.
- **D side with `dcache_read` and `dcache_write` both set:** this is illegal. The block treats it as a write, and the bench flags it with an assertion.
- **BUSY:** hold all `l2_*` outputs stable. Changes on L1 inputs are ignored.
- **BUSY with `l2_resp`=1:**
  - Capture `l2_rdata` into a 256-bit return buffer.
  - Clear `l2_read`/`l2_write`.
  - Go to DONE.
- **DONE:**
  - Assert `src`'s resp for exactly one cycle.
  - Both `*_rdata` outputs are driven from the return buffer.
  - Go to IDLE.
  - Requests seen during DONE are not granted; the requester drops its request on the cycle after resp.
- **Request withdrawn mid-BUSY:** the L2 transaction still completes and the resp pulse is still issued.
- **Write completion:** the resp pulse is issued the same way; `dcache_rdata` content is don't-care.

## Timing
- **Reset values:** all outputs are 0, state = IDLE, `last_grant` = I, buffers = 0.
  - Reset mid-transaction aborts immediately: `l2_read`/`l2_write` drop asynchronously and no resp is issued.
- **Grant:** request sampled in IDLE at cycle t gives `l2_read`/`l2_write` high from t+1.
- **Completion:** `l2_resp` first high at cycle k gives L1 resp at k+1 with data. The FSM is in IDLE at k+2.
- **Minimum round trip:** request at t, L2 resp at t+1, L1 resp at t+2.
- **Back-to-back:** the earliest next grant is at k+2, so `l2_read` reasserts at k+3.
  - The L2 request lines always have at least two low cycles between transactions, so the L2 control FSM sees a clean deassertion.
- **Multi-cycle `l2_resp`:** only the first cycle is acted on. Further cycles arrive in DONE/IDLE and are ignored.
- **No combinational paths:** no combinational path from any input to any output.

## Structure
- `arb_state_t` enum {IDLE, BUSY, DONE} and `arb_src_t` enum {SRC_I, SRC_D} go in `rv32i_types`.
- Single module, no sub-modules: a state register, a next-state `always_comb`, and registered datapath flops.

## Test plan
- **Lone I read:** `icache_read` at cycle 0 with address 0x0000_1234.
  - Cycle 1: `l2_read`=1, `l2_address`=0x0000_1220.
  - L2 resp at cycle 4 with data 0xAA..AA: cycle 5 `icache_resp`=1, `icache_rdata`=0xAA..AA.
- **Lone D write:** address 0x8000_0040, wdata 0x55..55.
  - `l2_write`=1 with that wdata until `l2_resp`.
  - `dcache_resp` pulses exactly one cycle later.
  - `icache_resp` stays 0 throughout.
- **Contention after reset:** both sides request at cycle 0.
  - D is served first, then I.
  - A third simultaneous request is granted to D again (alternation).
- **Withdrawn request:** `icache_read` dropped during BUSY. `l2_read` stays high until `l2_resp`, and the `icache_resp` pulse is still issued.
- **Reset mid-BUSY:** `rst` pulsed while `l2_read`=1.
  - All outputs go to 0 immediately, state returns to IDLE, and no resp is issued.
  - The next request is granted normally.
- **3-cycle `l2_resp`:** a single L1 resp pulse, with no spurious re-grant.
